systolic_seq: RTL and testbench
===============================

Name: systolic_seq

Overview:
- Sequencer for a ROWS x COLS systolic array of weight-stationary PE tiles.
- Per command, it optionally streams a new weight tile into the array's background registers, then pulses the per-row weight switch.
- It then issues input-buffer reads and drives skewed per-row valids and per-column output-capture strobes, so the south-edge psums land in the result buffer.
- It sits between the command front-end and the array/buffer datapath; it carries no data, only control.

Parameters:
- ROWS, 2, array rows (>=1).
- COLS, 2, array columns (>=1).
- LEN_W, 8, width of the command vector count and input read address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer idle; a command is accepted on a clock edge where cmd_valid&cmd_ready.
- cmd_load_w  in  1  1 = load a new weight tile before streaming; 0 = reuse the active weights.
- cmd_len  in  LEN_W  number of input vectors K (1..2^LEN_W-1).
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse, command complete.
- w_rd_en  out  1  weight-buffer read (1-cycle read latency).
- w_rd_addr  out  max(1,$clog2(ROWS))  weight row index.
- arr_enable  out  1  array enable (PE enable input).
- arr_accept_w  out  1  broadcast weight-accept to all PEs.
- arr_switch  out  ROWS  per-row switch into west column.
- x_rd_en  out  1  input-buffer read, unskewed (row-0 timing).
- x_rd_addr  out  LEN_W  input vector index.
- arr_valid  out  ROWS  per-row west-edge valid, row r skewed by r.
- col_capture  out  COLS  result capture strobe for south edge of column c.
- perf_busy_cycles  out  32  see Optional Feature.
- perf_cmds  out  16  see Optional Feature.

Behaviour:
- Reset (rst=0 at an edge):
  - All outputs are registered-low: arr_enable=0, which clears every PE; cmd_ready=0; perf counters=0.
  - State goes to IDLE. Reset mid-command aborts it with no done pulse.
  - The first edge with rst=1 sets arr_enable=1; arr_enable then stays 1.
- States: IDLE -> (WLOAD if cmd_load_w) -> STREAM -> DRAIN -> DONE -> IDLE.
  - cmd_ready = (state==IDLE) & rst.
  - busy=1 in every state except IDLE.
- Command rejection: a command offered with cmd_len==0 is not executed.
  - cmd_err pulses on the following cycle.
  - The sequencer stays in IDLE and cmd_ready stays 1.
- Cycle numbering: cycle 0 is the first cycle after the accepting edge. K = latched cmd_len. S = ROWS+1 if cmd_load_w, else 0.
- WLOAD (cmd_load_w=1 only):
  - w_rd_en=1 for cycles 0..ROWS-1.
  - w_rd_addr = ROWS-1-i in cycle i, so the bottom row is fed first.
  - arr_accept_w=1 for cycles 1..ROWS.
- Switch: arr_switch[r] pulses in cycle S+r (load only). No switch is issued when cmd_load_w=0.
- STREAM:
  - x_rd_en=1 for cycles S..S+K-1, with x_rd_addr = cycle-S, counting 0..K-1.
  - arr_valid[r]=1 for cycles S+1+r..S+K+r.
  - The first valid reaches each PE one cycle after that PE's switch, so the new active weight is used.
- Capture: col_capture[c]=1 for cycles S+1+ROWS+c..S+K+ROWS+c.
- Completion: done pulses in cycle S+K+ROWS+COLS, which is the DONE state. The next command can be accepted at the edge ending the following IDLE cycle.
- Inactive outputs: all outputs not named as active in a cycle are 0. Inputs are sampled only on the accept edge; cmd_* changes mid-command are ignored.
- Counters: implemented as phase/cycle counters sized for the worst case S+K+ROWS+COLS; there is no wrap within a command.

Optional Feature:
- Macro: SYSTOLIC_SEQ_PERF_EN.
- Defined:
  - perf_busy_cycles increments every cycle busy=1.
  - perf_cmds increments on every done pulse.
  - Both saturate at all-ones and clear only on reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with cmd_valid=1 -> every output 0, no accept; release -> next cycle arr_enable=1, cmd_ready=1.
2. ROWS=COLS=2, load_w=1, len=3 ->
   - w_rd_en cycles 0-1, addr 1,0; accept_w cycles 1-2.
   - switch[0]@3, switch[1]@4.
   - x_rd_en 3-5, addr 0,1,2; valid[0] 4-6, valid[1] 5-7.
   - capture[0] 6-8, capture[1] 7-9; done@10; busy 0-10.
3. load_w=0, len=1 -> x_rd_en@0, valid[0]@1, valid[1]@2, capture[0]@3, capture[1]@4, done@5; w_rd_en, accept_w and switch stay 0.
4. cmd_len=0 with cmd_valid=1 -> cmd_err one pulse; cmd_ready remains 1; no other output toggles.
5. Reset mid-run: scenario 2 with rst=0 at cycle 4 -> next cycle all outputs 0, arr_enable=0, no done; after release, scenario 2 repeats with identical timing.
6. With SYSTOLIC_SEQ_PERF_EN, run scenario 2 then scenario 3 -> perf_cmds=2, perf_busy_cycles=17; without the macro, both read 0.

Source files
------------

// File: rtl/systolic_seq.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq
// Brief    : Control sequencer for a ROWS x COLS weight-stationary systolic
//            array. Per command it optionally streams a weight tile into the
//            background registers, pulses the per-row weight switch, issues
//            input-buffer reads, drives the skewed west-edge valids and the
//            south-edge capture strobes. Control only, no datapath.
// Options  : SYSTOLIC_SEQ_PERF_EN - builds the busy-cycle and command
//            counters; when undefined both perf ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_seq #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int LEN_W = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       cmd_valid,
    output logic                                       cmd_ready,
    input  logic                                       cmd_load_w,
    input  logic [LEN_W-1:0]                           cmd_len,
    output logic                                       cmd_err,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       w_rd_en,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] w_rd_addr,
    output logic                                       arr_enable,
    output logic                                       arr_accept_w,
    output logic [ROWS-1:0]                            arr_switch,
    output logic                                       x_rd_en,
    output logic [LEN_W-1:0]                           x_rd_addr,
    output logic [ROWS-1:0]                            arr_valid,
    output logic [COLS-1:0]                            col_capture,
    output logic [31:0]                                perf_busy_cycles,
    output logic [15:0]                                perf_cmds
);

    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Longest command: (ROWS+1) load cycles + (2^LEN_W-1) vectors + skew
    // through ROWS rows and COLS columns. The cycle counter must hold that
    // value without wrapping.
    localparam int CNT_W = $clog2(2 * ROWS + COLS + (1 << LEN_W) + 1);

    localparam logic [CNT_W-1:0] C_ZERO = '0;
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ROWS = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] C_COLS = CNT_W'(COLS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLOAD  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;          // cycle number within command
    logic               load_q, load_d;        // latched cmd_load_w
    logic [LEN_W-1:0]   len_q, len_d;          // latched cmd_len (K)

    // Command phase boundaries for the current (q) and next (d) cycle.
    logic [CNT_W-1:0]   s_q, x_end_q, t_end_q;
    logic [CNT_W-1:0]   s_d, x_end_d;

    logic               accept;
    logic               reject;
    logic               active_d;

    // Registered outputs and their next values.
    logic               w_rd_en_q, w_rd_en_d;
    logic [AW-1:0]      w_rd_addr_q, w_rd_addr_d;
    logic               accept_w_q, accept_w_d;
    logic [ROWS-1:0]    switch_q, switch_d;
    logic               x_rd_en_q, x_rd_en_d;
    logic [LEN_W-1:0]   x_rd_addr_q, x_rd_addr_d;
    logic [ROWS-1:0]    valid_q, valid_d;
    logic [COLS-1:0]    capture_q, capture_d;
    logic               done_q, done_d;
    logic               cmd_err_q;
    logic               arr_enable_q;

    assign cmd_ready = (state_q == ST_IDLE) & rst;
    assign busy      = (state_q != ST_IDLE);
    assign accept    = cmd_valid & cmd_ready & (cmd_len != '0);
    assign reject    = cmd_valid & cmd_ready & (cmd_len == '0);

    // S is the weight-load prologue length; zero when weights are reused.
    assign s_q     = load_q ? (C_ROWS + C_ONE) : C_ZERO;
    assign x_end_q = s_q + CNT_W'(len_q);
    assign t_end_q = x_end_q + C_ROWS + C_COLS;
    assign s_d     = load_d ? (C_ROWS + C_ONE) : C_ZERO;
    assign x_end_d = s_d + CNT_W'(len_d);

    // Next-state, cycle counter and command latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = C_ZERO;
                if (accept) begin
                    load_d  = cmd_load_w;
                    len_d   = cmd_len;
                    state_d = cmd_load_w ? ST_WLOAD : ST_STREAM;
                end
            end
            ST_WLOAD: begin
                cnt_d = cnt_q + C_ONE;
                if (cnt_q == C_ROWS) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                cnt_d = cnt_q + C_ONE;
                if ((cnt_q + C_ONE) == x_end_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + C_ONE;
                if ((cnt_q + C_ONE) == t_end_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = C_ZERO;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = C_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decode next-cycle outputs from the next cycle number so that every
    // output toggles straight off a flop.
    always_comb begin
        active_d    = (state_d == ST_WLOAD) || (state_d == ST_STREAM) ||
                      (state_d == ST_DRAIN);
        w_rd_en_d   = active_d && load_d && (cnt_d < C_ROWS);
        w_rd_addr_d = w_rd_en_d ? AW'(C_ROWS - C_ONE - cnt_d) : '0;
        accept_w_d  = active_d && load_d && (cnt_d >= C_ONE) && (cnt_d <= C_ROWS);
        x_rd_en_d   = active_d && (cnt_d >= s_d) && (cnt_d < x_end_d);
        x_rd_addr_d = x_rd_en_d ? LEN_W'(cnt_d - s_d) : '0;
        done_d      = (state_d == ST_DONE);
        switch_d    = '0;
        valid_d     = '0;
        capture_d   = '0;
        for (int r = 0; r < ROWS; r++) begin
            // Row r switches in cycle S+r; its first valid follows one cycle
            // later so the freshly switched weight is the one used.
            switch_d[r] = active_d && load_d && (cnt_d == (s_d + CNT_W'(r)));
            valid_d[r]  = active_d && (cnt_d > (s_d + CNT_W'(r))) &&
                          (cnt_d <= (x_end_d + CNT_W'(r)));
        end
        for (int c = 0; c < COLS; c++) begin
            capture_d[c] = active_d &&
                           (cnt_d > (s_d + C_ROWS + CNT_W'(c))) &&
                           (cnt_d <= (x_end_d + C_ROWS + CNT_W'(c)));
        end
    end

    // State register, cycle counter and latched command fields.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= C_ZERO;
            load_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            len_q   <= len_d;
        end
    end

    // Output registers; reset drives every strobe low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_rd_en_q   <= 1'b0;
            w_rd_addr_q <= '0;
            accept_w_q  <= 1'b0;
            switch_q    <= '0;
            x_rd_en_q   <= 1'b0;
            x_rd_addr_q <= '0;
            valid_q     <= '0;
            capture_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            w_rd_en_q   <= w_rd_en_d;
            w_rd_addr_q <= w_rd_addr_d;
            accept_w_q  <= accept_w_d;
            switch_q    <= switch_d;
            x_rd_en_q   <= x_rd_en_d;
            x_rd_addr_q <= x_rd_addr_d;
            valid_q     <= valid_d;
            capture_q   <= capture_d;
            done_q      <= done_d;
        end
    end

    // Array enable holds PEs cleared through reset; rejection pulse for len=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            arr_enable_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            arr_enable_q <= 1'b1;
            cmd_err_q    <= reject;
        end
    end

    assign w_rd_en      = w_rd_en_q;
    assign w_rd_addr    = w_rd_addr_q;
    assign arr_enable   = arr_enable_q;
    assign arr_accept_w = accept_w_q;
    assign arr_switch   = switch_q;
    assign x_rd_en      = x_rd_en_q;
    assign x_rd_addr    = x_rd_addr_q;
    assign arr_valid    = valid_q;
    assign col_capture  = capture_q;
    assign done         = done_q;
    assign cmd_err      = cmd_err_q;

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] perf_busy_q;
    logic [15:0] perf_cmds_q;

    // Saturating activity counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_busy_q <= '0;
            perf_cmds_q <= '0;
        end else begin
            if (busy && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (done_q && (perf_cmds_q != '1)) begin
                perf_cmds_q <= perf_cmds_q + 16'd1;
            end
        end
    end

    assign perf_busy_cycles = perf_busy_q;
    assign perf_cmds        = perf_cmds_q;
`else
    assign perf_busy_cycles = 32'd0;
    assign perf_cmds        = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_seq
// Brief    : Self-checking bench for systolic_seq. Expected per-cycle control
//            activity is built from a per-vector schedule of the command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_seq;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int LEN_W = 8;
    localparam int AW    = 1;
    localparam int MAXC  = 300;
    localparam int VW    = 8 + AW + LEN_W + 2 * ROWS + COLS;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_load_w = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_err;
    logic             busy;
    logic             done;
    logic             w_rd_en;
    logic [AW-1:0]    w_rd_addr;
    logic             arr_enable;
    logic             arr_accept_w;
    logic [ROWS-1:0]  arr_switch;
    logic             x_rd_en;
    logic [LEN_W-1:0] x_rd_addr;
    logic [ROWS-1:0]  arr_valid;
    logic [COLS-1:0]  col_capture;
    logic [31:0]      perf_busy_cycles;
    logic [15:0]      perf_cmds;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected schedule, one entry per command cycle.
    logic            e_rdy   [MAXC];
    logic            e_busy  [MAXC];
    logic            e_done  [MAXC];
    logic            e_wen   [MAXC];
    logic [AW-1:0]   e_waddr [MAXC];
    logic            e_acc   [MAXC];
    logic [ROWS-1:0] e_sw    [MAXC];
    logic            e_xen   [MAXC];
    logic [LEN_W-1:0] e_xaddr[MAXC];
    logic [ROWS-1:0] e_val   [MAXC];
    logic [COLS-1:0] e_cap   [MAXC];

    systolic_seq #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load_w(cmd_load_w), .cmd_len(cmd_len), .cmd_err(cmd_err),
        .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .arr_enable(arr_enable), .arr_accept_w(arr_accept_w),
        .arr_switch(arr_switch),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
        .arr_valid(arr_valid), .col_capture(col_capture),
        .perf_busy_cycles(perf_busy_cycles), .perf_cmds(perf_cmds)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1);
    end

    function automatic logic [VW-1:0] dut_vec();
        return {cmd_ready, cmd_err, busy, done, w_rd_en, w_rd_addr, arr_enable,
                arr_accept_w, arr_switch, x_rd_en, x_rd_addr, arr_valid,
                col_capture};
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int c);
        return {e_rdy[c], 1'b0, e_busy[c], e_done[c], e_wen[c], e_waddr[c], 1'b1,
                e_acc[c], e_sw[c], e_xen[c], e_xaddr[c], e_val[c], e_cap[c]};
    endfunction

    // Build the schedule: each weight row and each input vector j occupies a
    // fixed slot, then ripples one cycle per row (valid) and per column
    // (capture).
    task automatic build_model(input bit load, input int k, output int t);
        int s;
        s = load ? ROWS + 1 : 0;
        t = s + k + ROWS + COLS;
        for (int c = 0; c < MAXC; c++) begin
            e_rdy[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0;
            e_wen[c] = 1'b0; e_waddr[c] = '0; e_acc[c] = 1'b0; e_sw[c] = '0;
            e_xen[c] = 1'b0; e_xaddr[c] = '0; e_val[c] = '0; e_cap[c] = '0;
        end
        for (int c = 0; c <= t; c++) e_busy[c] = 1'b1;
        e_rdy[t + 1] = 1'b1;
        e_done[t] = 1'b1;
        if (load) begin
            for (int i = 0; i < ROWS; i++) begin
                e_wen[i]       = 1'b1;
                e_waddr[i]     = AW'(ROWS - 1 - i);
                e_acc[i + 1]   = 1'b1;
                e_sw[s + i][i] = 1'b1;
            end
        end
        for (int j = 0; j < k; j++) begin
            e_xen[s + j]   = 1'b1;
            e_xaddr[s + j] = LEN_W'(j);
            for (int r = 0; r < ROWS; r++) e_val[s + 1 + j + r][r] = 1'b1;
            for (int c = 0; c < COLS; c++) e_cap[s + 1 + j + ROWS + c][c] = 1'b1;
        end
    endtask

    // Offer one command from an idle cycle and check every cycle up to the
    // following idle cycle, or until abort_at where reset is asserted.
    task automatic run_cmd(input bit load, input int k, input int abort_at,
                           input string tag);
        int t;
        build_model(load, k, t);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before_accept: got %b want 1", tag, cmd_ready);
        end
        cmd_valid  = 1'b1;
        cmd_load_w = load;
        cmd_len    = k[LEN_W-1:0];
        @(posedge clk);
        #1;
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_load_w = 1'($urandom_range(0, 1));
        cmd_len    = LEN_W'($urandom);
        for (int c = 0; c <= t + 1; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec(c)) begin
                n_fail++;
                $display("FAIL %s cycle%0d: got %h want %h", tag, c, dut_vec(), exp_vec(c));
            end
            if (c == t) cmd_valid = 1'b0;
            if (c == abort_at) begin
                rst       = 1'b0;
                cmd_valid = 1'b0;
                break;
            end
        end
        if (abort_at >= 0) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== '0) begin
                n_fail++;
                $display("FAIL %s after_abort: got %h want 0", tag, dut_vec());
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b1; cmd_load_w = 1'b1; cmd_len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ((dut_vec() !== '0) || (perf_busy_cycles !== 32'd0) || (perf_cmds !== 16'd0)) begin
                n_fail++;
                $display("FAIL reset_hold%0d: got %h/%0d/%0d want 0/0/0", i, dut_vec(),
                         perf_busy_cycles, perf_cmds);
            end
        end
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({arr_enable, cmd_ready, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_release: got en/rdy/busy=%b want 110",
                     {arr_enable, cmd_ready, busy});
        end
    endtask

    task automatic test_load();
        run_cmd(1'b1, 3, -1, "load_len3");
    endtask

    task automatic test_reuse();
        run_cmd(1'b0, 1, -1, "reuse_len1");
    endtask

    task automatic test_reject();
        logic [VW-1:0] idle_v;
        logic [VW-1:0] err_v;
        idle_v = '0;
        idle_v[VW-1] = 1'b1;                          // cmd_ready
        idle_v[VW-6-AW] = 1'b1;                       // arr_enable
        err_v = idle_v;
        err_v[VW-2] = 1'b1;                           // cmd_err
        cmd_valid  = 1'b1;
        cmd_len    = '0;
        cmd_load_w = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== ((i == 0) ? err_v : idle_v)) begin
                n_fail++;
                $display("FAIL reject_cycle%0d: got %h want %h", i, dut_vec(),
                         (i == 0) ? err_v : idle_v);
            end
        end
    endtask

    task automatic test_reset_midrun();
        run_cmd(1'b1, 3, 4, "midrun_abort");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({arr_enable, cmd_ready, busy, done} !== 4'b1100) begin
            n_fail++;
            $display("FAIL midrun_release: got en/rdy/busy/done=%b want 1100",
                     {arr_enable, cmd_ready, busy, done});
        end
        run_cmd(1'b1, 3, -1, "midrun_repeat");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 10; n++) begin
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(1, 20)), -1, "random");
        end
    endtask

    task automatic test_max_len();
        run_cmd(1'b1, 255, -1, "maxlen_load");
        run_cmd(1'b0, 255, -1, "maxlen_reuse");
    endtask

    task automatic test_perf();
        logic [31:0] want_busy;
        logic [15:0] want_cmds;
`ifdef SYSTOLIC_SEQ_PERF_EN
        want_busy = 32'd17;
        want_cmds = 16'd2;
`else
        want_busy = 32'd0;
        want_cmds = 16'd0;
`endif
        apply_reset();
        run_cmd(1'b1, 3, -1, "perf_load");
        run_cmd(1'b0, 1, -1, "perf_reuse");
        n_checks++;
        if ((perf_busy_cycles !== want_busy) || (perf_cmds !== want_cmds)) begin
            n_fail++;
            $display("FAIL perf_counters: got busy=%0d cmds=%0d want busy=%0d cmds=%0d",
                     perf_busy_cycles, perf_cmds, want_busy, want_cmds);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_reuse();
        test_reject();
        test_reset_midrun();
        test_back_to_back();
        test_max_len();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
